// File: rtl/dmem_port_arbiter_if.sv
// Shared data-memory port bundle: CPU requester, loader requester and the memory side.
// The arbiter takes the slave view; the CPU/loader/memory environment takes the master view.
interface dmem_port_arbiter_if #(
  parameter int VLEN = 128
);
  logic            c_req;
  logic [31:0]     c_addr;
  logic [VLEN-1:0] c_wdata;
  logic [3:0]      c_wmem;
  logic            c_vector;
  logic            c_gnt;
  logic            c_valid;

  logic            l_req;
  logic [31:0]     l_addr;
  logic [VLEN-1:0] l_wdata;
  logic [3:0]      l_wmem;
  logic            l_vector;
  logic            l_lock;
  logic            l_gnt;
  logic            l_valid;

  logic [VLEN-1:0] rdata;

  logic [31:0]     m_addr;
  logic [VLEN-1:0] m_wdata;
  logic [3:0]      m_wmem;
  logic            m_vector;
  logic [VLEN-1:0] m_rdata;

  modport slave (
    input  c_req, c_addr, c_wdata, c_wmem, c_vector,
    output c_gnt, c_valid,
    input  l_req, l_addr, l_wdata, l_wmem, l_vector, l_lock,
    output l_gnt, l_valid,
    output rdata,
    output m_addr, m_wdata, m_wmem, m_vector,
    input  m_rdata
  );

  modport master (
    output c_req, c_addr, c_wdata, c_wmem, c_vector,
    input  c_gnt, c_valid,
    output l_req, l_addr, l_wdata, l_wmem, l_vector, l_lock,
    input  l_gnt, l_valid,
    input  rdata,
    input  m_addr, m_wdata, m_wmem, m_vector,
    output m_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// CPU/loader round-robin arbiter for one data-memory port; req->gnt 1 cycle, read data 2 cycles.
// Losers simply wait with req held (no queueing); loader lock bursts are capped at MAXBURST while the CPU waits.
module dmem_port_arbiter #(
  parameter int VLEN     = 128,
  parameter int MAXBURST = 4
) (
  input logic                clk,
  input logic                clrn,
  dmem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } owner_t;

  localparam logic [3:0] BURST_CAP = 4'(MAXBURST);

  owner_t          owner_q, owner_d;
  logic            last_ldr_q, last_ldr_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic            c_valid_q, l_valid_q;
  logic [VLEN-1:0] rdata_q;

  logic [31:0]     m_addr;
  logic [VLEN-1:0] m_wdata;
  logic [3:0]      m_wmem;
  logic            m_vector;
  logic            rd_cycle;

  // The current cycle's grant is folded into last_served and burst_cnt before
  // deciding, so a port that owns now counts as most recently served.
  always_comb begin
    last_ldr_d  = last_ldr_q;
    burst_cnt_d = '0;
    if (owner_q == OWN_CPU) begin
      last_ldr_d = 1'b0;
    end else if (owner_q == OWN_LDR) begin
      last_ldr_d  = 1'b1;
      burst_cnt_d = (burst_cnt_q < BURST_CAP) ? burst_cnt_q + 4'd1 : burst_cnt_q;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    case ({bus.c_req, bus.l_req})
      2'b10:   owner_d = OWN_CPU;
      2'b01:   owner_d = OWN_LDR;
      2'b11: begin
        if (owner_q == OWN_LDR && bus.l_lock && burst_cnt_d < BURST_CAP) begin
          owner_d = OWN_LDR;
        end else if (last_ldr_d) begin
          owner_d = OWN_CPU;
        end else begin
          owner_d = OWN_LDR;
        end
      end
      default: owner_d = OWN_NONE;
    endcase
  end

  always_comb begin
    m_addr   = '0;
    m_wdata  = '0;
    m_wmem   = '0;
    m_vector = 1'b0;
    if (owner_q == OWN_CPU) begin
      m_addr   = bus.c_addr;
      m_wdata  = bus.c_wdata;
      m_wmem   = bus.c_wmem;
      m_vector = bus.c_vector;
    end else if (owner_q == OWN_LDR) begin
      m_addr   = bus.l_addr;
      m_wdata  = bus.l_wdata;
      m_wmem   = bus.l_wmem;
      m_vector = bus.l_vector;
    end
  end

  assign rd_cycle = (owner_q != OWN_NONE) && (m_wmem == 4'd0);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      owner_q     <= OWN_NONE;
      last_ldr_q  <= 1'b1;
      burst_cnt_q <= '0;
      c_valid_q   <= 1'b0;
      l_valid_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      owner_q     <= owner_d;
      last_ldr_q  <= last_ldr_d;
      burst_cnt_q <= burst_cnt_d;
      c_valid_q   <= rd_cycle && (owner_q == OWN_CPU);
      l_valid_q   <= rd_cycle && (owner_q == OWN_LDR);
      if (rd_cycle) begin
        rdata_q <= bus.m_rdata;
      end
    end
  end

  assign bus.c_gnt    = (owner_q == OWN_CPU);
  assign bus.l_gnt    = (owner_q == OWN_LDR);
  assign bus.c_valid  = c_valid_q;
  assign bus.l_valid  = l_valid_q;
  assign bus.rdata    = rdata_q;
  assign bus.m_addr   = m_addr;
  assign bus.m_wdata  = m_wdata;
  assign bus.m_wmem   = m_wmem;
  assign bus.m_vector = m_vector;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 64 x 128-bit behavioural memory.
module tb_dmem_port_arbiter;
  localparam int VLEN = 128;
  typedef logic [127:0] w_t;
  localparam w_t PRESET = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   wr_snap;
  logic [VLEN-1:0] mem [0:63];
  logic [1:0] exp_alt [0:3];
  logic [1:0] exp_lock [0:6];

  dmem_port_arbiter_if #(.VLEN(VLEN)) bus ();

  dmem_port_arbiter #(.VLEN(VLEN), .MAXBURST(4)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.m_rdata = mem[bus.m_addr[9:4]];

  always @(posedge clk) begin
    if (bus.m_wmem != 4'd0) begin
      wr_cnt <= wr_cnt + 1;
      if (bus.m_vector) begin
        mem[bus.m_addr[9:4]] <= bus.m_wdata;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (bus.m_wmem[b])
            mem[bus.m_addr[9:4]][int'(bus.m_addr[3:2])*32 + b*8 +: 8] <= bus.m_wdata[b*8 +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= {4{32'(i)}};
    mem[16] <= PRESET;
    exp_alt  = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_lock = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

    bus.c_req = 0; bus.c_addr = '0; bus.c_wdata = '0; bus.c_wmem = '0; bus.c_vector = 0;
    bus.l_req = 0; bus.l_addr = '0; bus.l_wdata = '0; bus.l_wmem = '0; bus.l_vector = 0;
    bus.l_lock = 0;

    // Reset state
    #3;
    chk("rst_gnt",   w_t'({bus.c_gnt, bus.l_gnt}), w_t'(2'b00));
    chk("rst_valid", w_t'({bus.c_valid, bus.l_valid}), w_t'(2'b00));
    chk("rst_rdata", w_t'(bus.rdata), w_t'(0));
    chk("rst_mbus",  w_t'({bus.m_addr, bus.m_wmem, bus.m_vector}), w_t'(0));

    // CPU vector read of the preset word
    tick();
    clrn = 1;
    bus.c_req = 1; bus.c_addr = 32'h100; bus.c_vector = 1; bus.c_wmem = 4'h0;
    tick();
    chk("rd_gnt",   w_t'({bus.c_gnt, bus.l_gnt}), w_t'(2'b10));
    chk("rd_maddr", w_t'(bus.m_addr), w_t'(32'h100));
    chk("rd_mvec",  w_t'(bus.m_vector), w_t'(1));
    bus.c_req = 0;
    tick();
    chk("rd_gnt_off", w_t'(bus.c_gnt), w_t'(0));
    chk("rd_valid",   w_t'({bus.c_valid, bus.l_valid}), w_t'(2'b10));
    chk("rd_data",    bus.rdata, PRESET);
    tick();
    chk("rd_valid_pulse", w_t'(bus.c_valid), w_t'(0));

    // Tie from reset alternates C,L,C,L
    clrn = 0;
    tick();
    clrn = 1;
    bus.c_req = 1; bus.c_addr = 32'h40; bus.c_wdata = 128'h1234; bus.c_wmem = 4'h3; bus.c_vector = 0;
    bus.l_req = 1; bus.l_addr = 32'h80; bus.l_wdata = 128'hBEEF_0000; bus.l_wmem = 4'hC; bus.l_vector = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("alt_gnt",  w_t'({bus.c_gnt, bus.l_gnt}), w_t'(exp_alt[i]));
      chk("alt_wmem", w_t'(bus.m_wmem), (i % 2 == 0) ? w_t'(4'h3) : w_t'(4'hC));
    end
    bus.c_req = 0; bus.l_req = 0;
    tick();
    chk("alt_cpu_mem", w_t'(mem[4][15:0]), w_t'(16'h1234));
    chk("alt_ldr_mem", w_t'(mem[8][31:16]), w_t'(16'hBEEF));

    // Loader lock with CPU idle: unlimited, then reset mid-burst
    bus.l_req = 1; bus.l_lock = 1; bus.l_addr = 32'h200; bus.l_wmem = 4'hF; bus.l_vector = 1;
    bus.l_wdata = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("hold_lgnt", w_t'({bus.c_gnt, bus.l_gnt}), w_t'(2'b01));
      tick();
    end
    clrn = 0;
    #1;
    chk("mid_rst_gnt",  w_t'({bus.c_gnt, bus.l_gnt}), w_t'(2'b00));
    chk("mid_rst_mbus", w_t'({bus.m_addr, bus.m_wmem}), w_t'(0));
    wr_snap = wr_cnt;
    tick();
    chk("mid_rst_nowr", w_t'(wr_cnt), w_t'(wr_snap));
    chk("hold_mem",     mem[32], w_t'(128'hCAFE_F00D_0000_1111_2222_3333_4444_5555));
    clrn = 1;
    chk("rel_gnt0", w_t'(bus.l_gnt), w_t'(0));
    tick();
    chk("rel_gnt1", w_t'(bus.l_gnt), w_t'(1));
    bus.l_req = 0; bus.l_lock = 0;
    tick();

    // Contention with lock: CPU, 4 loader grants, CPU, loader resumes
    bus.c_req = 1; bus.c_addr = 32'h40; bus.c_wmem = 4'h1; bus.c_vector = 0;
    bus.l_req = 1; bus.l_lock = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("lock_gnt", w_t'({bus.c_gnt, bus.l_gnt}), w_t'(exp_lock[i]));
    end
    bus.c_req = 0; bus.l_req = 0; bus.l_lock = 0;
    tick();

    // Loader request withdrawn before it is ever sampled
    bus.c_req = 1; bus.c_addr = 32'h100; bus.c_wmem = 4'h0; bus.c_vector = 1;
    tick();
    chk("wd_cgnt", w_t'({bus.c_gnt, bus.l_gnt}), w_t'(2'b10));
    bus.l_req = 1; bus.l_addr = 32'h300; bus.l_wmem = 4'hF; bus.l_vector = 1;
    bus.l_wdata = 128'hDEAD;
    #2;
    chk("wd_mwmem", w_t'(bus.m_wmem), w_t'(0));
    chk("wd_maddr", w_t'(bus.m_addr), w_t'(32'h100));
    #2;
    bus.l_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_no_lgnt", w_t'(bus.l_gnt), w_t'(0));
    end
    chk("wd_mem", mem[48], w_t'(128'h00000030_00000030_00000030_00000030));
    bus.c_req = 0;
    tick();

    // Idle: nothing reaches memory
    wr_snap = wr_cnt;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_wmem", w_t'(bus.m_wmem), w_t'(0));
    end
    chk("idle_wrcnt", w_t'(wr_cnt), w_t'(wr_snap));
    chk("idle_mem",   mem[16], PRESET);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
